// File: rtl/r_type_pipeline.sv
// r_type_pipeline
//   Two-stage R-type integer pipeline with a resettable register file.
//   S1 holds the accepted instruction fields. When S1 advances, operands are
//   read, the ALU result is computed, S2 (the output register) is loaded and
//   the destination register is written back, all at the same clock edge.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready         instruction handshake (rs, rt, rd, funct)
//   out_valid/out_ready       result handshake (out_rd, out_result, flags)
//   out_zero                  result == 0
//   out_overflow              signed add/sub overflow (register not written)
//   out_illegal               unsupported funct (result 0, register not written)
//   ld_en/ld_addr/ld_data     register preload; a same-edge pipeline write wins
//   dbg_addr/dbg_data         combinational register read, address 0 reads 0
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// Once valid is raised it stays high and its payload stays stable until that
// transfer; ready may depend combinationally on the consumer side.
module r_type_pipeline #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [5:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_overflow,
  output logic              out_illegal,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int REGS = 2 ** ADDR_W;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // S1 stage
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_rs_q, s1_rs_d;
  logic [ADDR_W-1:0] s1_rt_q, s1_rt_d;
  logic [ADDR_W-1:0] s1_rd_q, s1_rd_d;
  logic [5:0]        s1_funct_q, s1_funct_d;

  // S2 stage (output register)
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_rd_q, out_rd_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic              out_zero_q, out_zero_d;
  logic              out_overflow_q, out_overflow_d;
  logic              out_illegal_q, out_illegal_d;

  // Register file
  logic [DATA_W-1:0] regs_q [REGS];
  logic [DATA_W-1:0] regs_d [REGS];

  // Datapath
  logic              s1_adv;
  logic              in_accept;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_overflow;
  logic              alu_illegal;
  logic              wb_en;

  assign s1_adv    = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s1_adv;
  assign in_accept = in_valid && in_ready;

  // Operands are read when S1 advances, i.e. after any older instruction has
  // already written back, so dependent instructions never need forwarding.
  assign op_a = (s1_rs_q == '0) ? '0 : regs_q[s1_rs_q];
  assign op_b = (s1_rt_q == '0) ? '0 : regs_q[s1_rt_q];

  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    alu_illegal  = 1'b0;
    case (s1_funct_q)
      FUNCT_ADD: begin
        alu_result   = op_a + op_b;
        alu_overflow = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                       (alu_result[DATA_W-1] != op_a[DATA_W-1]);
      end
      FUNCT_SUB: begin
        alu_result   = op_a - op_b;
        alu_overflow = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                       (alu_result[DATA_W-1] != op_a[DATA_W-1]);
      end
      FUNCT_AND: alu_result = op_a & op_b;
      FUNCT_OR:  alu_result = op_a | op_b;
      FUNCT_NOR: alu_result = ~(op_a | op_b);
      FUNCT_SLT: alu_result = ($signed(op_a) < $signed(op_b)) ?
                              {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      default:   alu_illegal = 1'b1;
    endcase
  end

  assign wb_en = s1_adv && !alu_overflow && !alu_illegal && (s1_rd_q != '0);

  // S1 next state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_rs_d    = s1_rs_q;
    s1_rt_d    = s1_rt_q;
    s1_rd_d    = s1_rd_q;
    s1_funct_d = s1_funct_q;
    if (in_accept) begin
      s1_valid_d = 1'b1;
      s1_rs_d    = rs;
      s1_rt_d    = rt;
      s1_rd_d    = rd;
      s1_funct_d = funct;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 next state: payload only changes when a new result is loaded, which
  // keeps every out_* signal stable while the consumer stalls.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_rd_d       = out_rd_q;
    out_result_d   = out_result_q;
    out_zero_d     = out_zero_q;
    out_overflow_d = out_overflow_q;
    out_illegal_d  = out_illegal_q;
    if (s1_adv) begin
      out_valid_d    = 1'b1;
      out_rd_d       = s1_rd_q;
      out_result_d   = alu_result;
      out_zero_d     = (alu_result == '0);
      out_overflow_d = alu_overflow;
      out_illegal_d  = alu_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Register file next state: the pipeline write is applied last so it wins
  // over a preload to the same address.
  always_comb begin
    regs_d = regs_q;
    if (ld_en && (ld_addr != '0)) regs_d[ld_addr] = ld_data;
    if (wb_en) regs_d[s1_rd_q] = alu_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_rs_q        <= '0;
      s1_rt_q        <= '0;
      s1_rd_q        <= '0;
      s1_funct_q     <= '0;
      out_valid_q    <= 1'b0;
      out_rd_q       <= '0;
      out_result_q   <= '0;
      out_zero_q     <= 1'b0;
      out_overflow_q <= 1'b0;
      out_illegal_q  <= 1'b0;
      for (int i = 0; i < REGS; i++) regs_q[i] <= DATA_W'(i);
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_rs_q        <= s1_rs_d;
      s1_rt_q        <= s1_rt_d;
      s1_rd_q        <= s1_rd_d;
      s1_funct_q     <= s1_funct_d;
      out_valid_q    <= out_valid_d;
      out_rd_q       <= out_rd_d;
      out_result_q   <= out_result_d;
      out_zero_q     <= out_zero_d;
      out_overflow_q <= out_overflow_d;
      out_illegal_q  <= out_illegal_d;
      for (int i = 0; i < REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rd       = out_rd_q;
  assign out_result   = out_result_q;
  assign out_zero     = out_zero_q;
  assign out_overflow = out_overflow_q;
  assign out_illegal  = out_illegal_q;
  assign dbg_data     = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_r_type_pipeline.sv
// tb_r_type_pipeline
//   Directed bench for r_type_pipeline with hand-computed expected values.
//   Inputs change 1 ns after a rising edge; outputs are sampled in that same
//   window, so each sample reflects the state produced by the preceding edge.
module tb_r_type_pipeline;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [5:0]        funct;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_rd;
  logic [DATA_W-1:0] out_result;
  logic              out_zero, out_overflow, out_illegal;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  int checks = 0;
  int errors = 0;

  r_type_pipeline #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .rd(rd), .funct(funct),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_result(out_result),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_illegal(out_illegal),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive_instr(input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] d, input logic [5:0] f);
    in_valid = 1'b1;
    rs = a; rt = b; rd = d; funct = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    rs = '0; rt = '0; rd = '0; funct = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if ({out_rd, out_result, out_zero, out_overflow, out_illegal} !== '0) begin errors++; $display("FAIL rst_out_fields got rd %h res %h flags %b%b%b exp all 0", out_rd, out_result, out_zero, out_overflow, out_illegal); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    dbg_addr = 5'd0; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL rst_r0 got %h exp 0", dbg_data); end
    dbg_addr = 5'd5; #1;
    checks++; if (dbg_data !== 32'd5) begin errors++; $display("FAIL rst_r5 got %h exp 5", dbg_data); end
    dbg_addr = 5'd31; #1;
    checks++; if (dbg_data !== 32'd31) begin errors++; $display("FAIL rst_r31 got %h exp 1f", dbg_data); end
    step();
    rst = 1'b0;
    step();
  endtask

  // add r7 = r3 + r5 = 8
  task automatic test_add();
    drive_instr(5'd3, 5'd5, 5'd7, 6'b100000);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency got out_valid %b exp 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd8 || out_rd !== 5'd7 || out_zero !== 1'b0) begin errors++; $display("FAIL add_result got v %b res %h rd %0d z %b exp v 1 res 8 rd 7 z 0", out_valid, out_result, out_rd, out_zero); end
    dbg_addr = 5'd7; #1;
    checks++; if (dbg_data !== 32'd8) begin errors++; $display("FAIL add_wb got %h exp 8", dbg_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got out_valid %b exp 0", out_valid); end
  endtask

  // add r7 = r3 + r5 (8), then sub r8 = r7 - r3 (5), issued on consecutive edges
  task automatic test_back_to_back();
    drive_instr(5'd3, 5'd5, 5'd7, 6'b100000);
    step();
    drive_instr(5'd7, 5'd3, 5'd8, 6'b100010);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd8 || out_rd !== 5'd7) begin errors++; $display("FAIL b2b_first got v %b res %h rd %0d exp v 1 res 8 rd 7", out_valid, out_result, out_rd); end
    step();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd5 || out_rd !== 5'd8) begin errors++; $display("FAIL b2b_second got v %b res %h rd %0d exp v 1 res 5 rd 8", out_valid, out_result, out_rd); end
    step();
  endtask

  // preload r1 = 0x7FFFFFFF, add r2 = r1 + r1 overflows and leaves r2 = 2
  task automatic test_overflow();
    ld_en = 1'b1; ld_addr = 5'd1; ld_data = 32'h7FFF_FFFF;
    step();
    ld_en = 1'b0;
    dbg_addr = 5'd1; #1;
    checks++; if (dbg_data !== 32'h7FFF_FFFF) begin errors++; $display("FAIL preload_r1 got %h exp 7fffffff", dbg_data); end
    drive_instr(5'd1, 5'd1, 5'd2, 6'b100000);
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFE || out_overflow !== 1'b1 || out_zero !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("FAIL ovf_result got v %b res %h ovf %b z %b ill %b exp v 1 res fffffffe ovf 1 z 0 ill 0", out_valid, out_result, out_overflow, out_zero, out_illegal); end
    dbg_addr = 5'd2; #1;
    checks++; if (dbg_data !== 32'd2) begin errors++; $display("FAIL ovf_no_wb got %h exp 2", dbg_data); end
    step();
  endtask

  // and r10 = r6 & r3 (2), or r11 = r4 | r3 (7), add r12 = r11 + r10 (9)
  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_instr(5'd6, 5'd3, 5'd10, 6'b100100);
    step();
    drive_instr(5'd4, 5'd3, 5'd11, 6'b100101);
    step();
    drive_instr(5'd11, 5'd10, 5'd12, 6'b100000);
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd2 || out_rd !== 5'd10) begin errors++; $display("FAIL bp_first got v %b res %h rd %0d exp v 1 res 2 rd 10", out_valid, out_result, out_rd); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd2 || out_rd !== 5'd10 || out_zero !== 1'b0) begin errors++; $display("FAIL bp_hold cycle %0d got rdy %b v %b res %h rd %0d exp rdy 0 v 1 res 2 rd 10", i, in_ready, out_valid, out_result, out_rd); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd7 || out_rd !== 5'd11) begin errors++; $display("FAIL bp_second got v %b res %h rd %0d exp v 1 res 7 rd 11", out_valid, out_result, out_rd); end
    step();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd9 || out_rd !== 5'd12) begin errors++; $display("FAIL bp_third got v %b res %h rd %0d exp v 1 res 9 rd 12", out_valid, out_result, out_rd); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got out_valid %b exp 0", out_valid); end
  endtask

  // and r0 = r31 & r31, slt r9 = r0 < r31, illegal funct to r13
  task automatic test_r0_slt_illegal();
    drive_instr(5'd31, 5'd31, 5'd0, 6'b100100);
    step();
    drive_instr(5'd0, 5'd31, 5'd9, 6'b101010);
    step();
    drive_instr(5'd1, 5'd2, 5'd13, 6'b000001);
    checks++; if (out_result !== 32'd31 || out_rd !== 5'd0) begin errors++; $display("FAIL r0_and got res %h rd %0d exp res 1f rd 0", out_result, out_rd); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd1 || out_rd !== 5'd9) begin errors++; $display("FAIL slt_result got v %b res %h rd %0d exp v 1 res 1 rd 9", out_valid, out_result, out_rd); end
    step();
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b1 || out_overflow !== 1'b0) begin errors++; $display("FAIL illegal_result got v %b ill %b res %h z %b ovf %b exp v 1 ill 1 res 0 z 1 ovf 0", out_valid, out_illegal, out_result, out_zero, out_overflow); end
    dbg_addr = 5'd0; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL r0_stays got %h exp 0", dbg_data); end
    dbg_addr = 5'd9; #1;
    checks++; if (dbg_data !== 32'd1) begin errors++; $display("FAIL slt_wb got %h exp 1", dbg_data); end
    dbg_addr = 5'd13; #1;
    checks++; if (dbg_data !== 32'd13) begin errors++; $display("FAIL illegal_no_wb got %h exp d", dbg_data); end
    step();
  endtask

  // add r14 = r3 + r4 (7) while a preload to r14 lands on the same edge
  task automatic test_preload_collision();
    drive_instr(5'd3, 5'd4, 5'd14, 6'b100000);
    step();
    in_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 5'd14; ld_data = 32'h0000_00AA;
    step();
    ld_en = 1'b0;
    dbg_addr = 5'd14; #1;
    checks++; if (dbg_data !== 32'd7) begin errors++; $display("FAIL collision_wins got %h exp 7", dbg_data); end
    step();
  endtask

  // Two instructions in flight when rst is raised
  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive_instr(5'd3, 5'd3, 5'd15, 6'b100000);
    step();
    drive_instr(5'd4, 5'd4, 5'd16, 6'b100000);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_inflight got v %b rdy %b exp v 1 rdy 0", out_valid, in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0) begin errors++; $display("FAIL mid_rst_out got v %b res %h rd %0d exp v 0 res 0 rd 0", out_valid, out_result, out_rd); end
    dbg_addr = 5'd9; #1;
    checks++; if (dbg_data !== 32'd9) begin errors++; $display("FAIL mid_rst_r9 got %h exp 9", dbg_data); end
    dbg_addr = 5'd15; #1;
    checks++; if (dbg_data !== 32'd15) begin errors++; $display("FAIL mid_rst_r15 got %h exp f", dbg_data); end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
    step();
    step();
    dbg_addr = 5'd16; #1;
    checks++; if (out_valid !== 1'b0 || dbg_data !== 32'd16) begin errors++; $display("FAIL mid_no_wb got v %b r16 %h exp v 0 r16 10", out_valid, dbg_data); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_r0_slt_illegal();
    test_preload_collision();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
